// File: rtl/alu_seq.sv
// Sequences one 8085 ALU op: latch request, drive ALU, capture result, write back ACC/FLG.
// Latency: accept at edge 0, oDone in cycle 3, oRdy again from cycle 4; requests outside IDLE are dropped (no queuing).
module alu_seq #(
  parameter int DATASIZE = 8,
  parameter int FLAG_S   = 7,
  parameter int FLAG_Z   = 6,
  parameter int FLAG_A   = 4,
  parameter int FLAG_P   = 2,
  parameter int FLAG_C   = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                iReq,
  input  logic [2:0]          iOp,
  input  logic                iLd,
  input  logic [DATASIZE-1:0] iDat,
  output logic                oRdy,
  output logic                oDone,
  output logic [DATASIZE-1:0] oAcc,
  output logic [DATASIZE-1:0] oFlg,
  output logic [2:0]          oS,
  output logic [DATASIZE-1:0] oA,
  output logic [DATASIZE-1:0] oB,
  output logic [DATASIZE-1:0] oF,
  input  logic [DATASIZE-1:0] iY,
  input  logic [DATASIZE-1:0] iF
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_CMP = 3'b111;

  // Only the architected flag bits survive write-back; the unused positions read 0.
  localparam logic [DATASIZE-1:0] FLG_MASK =
      (DATASIZE'(1) << FLAG_S) | (DATASIZE'(1) << FLAG_Z) | (DATASIZE'(1) << FLAG_A) |
      (DATASIZE'(1) << FLAG_P) | (DATASIZE'(1) << FLAG_C);

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          op;
  logic [DATASIZE-1:0] acc;
  logic [DATASIZE-1:0] tmp;
  logic [DATASIZE-1:0] flg;
  logic [DATASIZE-1:0] res_y;
  logic [DATASIZE-1:0] res_f;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    oRdy      = 1'b0;
    oDone     = 1'b0;
    case (state)
      IDLE: begin
        oRdy = 1'b1;
        if (iReq) state_nxt = FETCH;
      end
      FETCH: state_nxt = EXEC;
      EXEC:  state_nxt = WRITE;
      WRITE: begin
        oDone     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op    <= '0;
      acc   <= '0;
      tmp   <= '0;
      flg   <= '0;
      res_y <= '0;
      res_f <= '0;
      oS    <= '0;
      oA    <= '0;
      oB    <= '0;
      oF    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iReq) begin
            op  <= iOp;
            tmp <= iDat;
          end else if (iLd) begin
            acc <= iDat;
          end
        end
        FETCH: begin
          oS <= op;
          oA <= acc;
          oB <= tmp;
          oF <= flg;
        end
        EXEC: begin
          res_y <= iY;
          res_f <= iF;
        end
        WRITE: begin
          flg <= res_f & FLG_MASK;
          if (op != OP_CMP) acc <= res_y;
        end
        default: ;
      endcase
    end
  end

  assign oAcc = acc;
  assign oFlg = flg;

endmodule

// File: tb/tb_alu_seq.sv
// Random and directed bench for alu_seq with a behavioural 8085 ALU and reference ACC/FLG model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       iReq;
  logic [2:0] iOp;
  logic       iLd;
  logic [7:0] iDat;
  logic       oRdy;
  logic       oDone;
  logic [7:0] oAcc;
  logic [7:0] oFlg;
  logic [2:0] oS;
  logic [7:0] oA;
  logic [7:0] oB;
  logic [7:0] oF;
  logic [7:0] iY;
  logic [7:0] iF;

  int checks = 0;
  int failures = 0;
  int exp_done = 0;
  int done_seen = 0;
  logic [7:0] m_acc;
  logic [7:0] m_flg;

  alu_seq dut (
    .clk(clk), .rstn(rstn), .iReq(iReq), .iOp(iOp), .iLd(iLd), .iDat(iDat),
    .oRdy(oRdy), .oDone(oDone), .oAcc(oAcc), .oFlg(oFlg),
    .oS(oS), .oA(oA), .oB(oB), .oF(oF), .iY(iY), .iF(iF)
  );

  always #5 clk = ~clk;

  // 8085 ALU; flag bits 5/1 and 3 carry junk so the write-back masking is exercised.
  function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] fin);
    int ai, bi, ci, s, lo;
    logic [7:0] y;
    logic c, ac;
    ai = int'(a);
    bi = int'(b);
    ci = (op == 3'd1 || op == 3'd3) ? int'(fin[0]) : 0;
    c = 1'b0; ac = 1'b0; y = 8'h00;
    s = 0; lo = 0;
    case (op)
      3'd0, 3'd1: begin
        s = ai + bi + ci; lo = (ai % 16) + (bi % 16) + ci;
        y = s[7:0]; c = (s > 255); ac = (lo > 15);
      end
      3'd2, 3'd3, 3'd7: begin
        s = ai - bi - ci; lo = (ai % 16) - (bi % 16) - ci;
        y = s[7:0]; c = (s < 0); ac = (lo < 0);
      end
      3'd4: begin y = a & b; ac = a[3] | b[3]; end
      3'd5: y = a ^ b;
      default: y = a | b;
    endcase
    return {y[7], (y == 8'h00), a[0], ac, b[0], ~^y, 1'b1, c, y};
  endfunction

  assign {iF, iY} = alu_calc(oS, oA, oB, oF);

  always @(negedge clk) if (oDone === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ld(input logic [7:0] d);
    iLd = 1'b1; iReq = 1'b0; iDat = d;
    tick();
    iLd = 1'b0;
    m_acc = d;
    check("ld_acc", oAcc, m_acc);
    check("ld_flg", oFlg, m_flg);
    check("ld_done", oDone, 1'b0);
    check("ld_rdy", oRdy, 1'b1);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] dat, input bit with_ld, input bit noise);
    logic [15:0] r;
    logic [7:0] old_acc, old_flg;
    old_acc = m_acc;
    old_flg = m_flg;
    check("rdy_idle", oRdy, 1'b1);
    iReq = 1'b1; iOp = op; iDat = dat; iLd = with_ld;
    tick();
    check("rdy_fetch", oRdy, 1'b0);
    check("done_fetch", oDone, 1'b0);
    if (noise) begin
      iReq = 1'b1; iOp = 3'($urandom); iDat = 8'($urandom); iLd = 1'($urandom);
    end else begin
      iReq = 1'b0; iLd = 1'b0;
    end
    tick();
    check("exec_s", oS, op);
    check("exec_a", oA, old_acc);
    check("exec_b", oB, dat);
    check("exec_f", oF, old_flg);
    check("rdy_exec", oRdy, 1'b0);
    check("done_exec", oDone, 1'b0);
    tick();
    check("done_write", oDone, 1'b1);
    check("rdy_write", oRdy, 1'b0);
    check("acc_write", oAcc, old_acc);
    iReq = 1'b0; iLd = 1'b0;
    r = alu_calc(op, old_acc, dat, old_flg);
    m_flg = r[15:8] & 8'hD5;
    if (op != 3'b111) m_acc = r[7:0];
    exp_done++;
    tick();
    check("done_after", oDone, 1'b0);
    check("rdy_after", oRdy, 1'b1);
    check("op_acc", oAcc, m_acc);
    check("op_flg", oFlg, m_flg);
    check("hold_s", oS, op);
    check("hold_b", oB, dat);
  endtask

  initial begin
    rstn = 1'b0; iReq = 1'b0; iOp = 3'd0; iLd = 1'b0; iDat = 8'h00;
    m_acc = 8'h00; m_flg = 8'h00;
    #12;
    check("rst_acc", oAcc, 8'h00);
    check("rst_flg", oFlg, 8'h00);
    check("rst_rdy", oRdy, 1'b1);
    check("rst_done", oDone, 1'b0);
    check("rst_drive", {oS, oA, oB, oF}, 32'h0);
    rstn = 1'b1;
    tick();

    do_ld(8'h3C);
    do_op(3'd0, 8'hC8, 1'b0, 1'b0);
    check("add_acc", oAcc, 8'h04);
    check("add_c", oFlg[0], 1'b1);
    do_op(3'd1, 8'h10, 1'b0, 1'b0);
    check("adc_acc", oAcc, 8'h15);
    check("adc_c", oFlg[0], 1'b0);
    do_ld(8'h10);
    do_op(3'd2, 8'h20, 1'b0, 1'b0);
    check("sub_acc", oAcc, 8'hF0);
    check("sub_c", oFlg[0], 1'b1);
    check("sub_rsvd", oFlg & 8'h2A, 8'h00);
    do_ld(8'h55);
    do_op(3'd7, 8'h55, 1'b0, 1'b1);
    check("cmp_acc", oAcc, 8'h55);
    check("cmp_zc", {oFlg[6], oFlg[0]}, 2'b10);
    do_ld(8'h00);
    do_op(3'd6, 8'h0F, 1'b1, 1'b0);
    check("or_acc", oAcc, 8'h0F);

    do_ld(8'h7F);
    iReq = 1'b1; iOp = 3'd0; iDat = 8'h01;
    tick();
    iReq = 1'b0;
    tick();
    #2 rstn = 1'b0;
    #1;
    m_acc = 8'h00; m_flg = 8'h00;
    check("abort_acc", oAcc, 8'h00);
    check("abort_flg", oFlg, 8'h00);
    check("abort_rdy", oRdy, 1'b1);
    check("abort_done", oDone, 1'b0);
    #2 rstn = 1'b1;
    tick();
    check("post_abort_done", oDone, 1'b0);
    check("post_abort_acc", oAcc, 8'h00);
    tick();
    check("post_abort_done2", oDone, 1'b0);
    do_op(3'd0, 8'h01, 1'b0, 1'b0);
    check("post_abort_add", oAcc, 8'h01);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(3) == 0) begin
        do_ld(8'($urandom));
      end else begin
        do_op(3'($urandom_range(7)), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      if ($urandom_range(4) == 0) begin
        tick();
        check("idle_done", oDone, 1'b0);
      end
    end

    tick();
    check("done_count", done_seen, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
